// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants and saturating-increment helper for the counter family
package counter_pkg;
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
      logic [31:0] top;
      top = (32'd1 << width) - 32'd1;
      return (value >= top) ? top : value + 32'd1;
   endfunction
endpackage

// File: rtl/counter_nbit_next.sv
// counter_nbit_next: next-count and terminal-event decode for a modulus up/down counter
import counter_pkg::*;

module counter_nbit_next #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] max,
   input  logic             m,
   input  logic             sat,
   output logic [WIDTH-1:0] next_q,
   output logic             term
);
   localparam logic [WIDTH:0] ONE = 1;
   logic             up;
   logic [WIDTH-1:0] inc_q;
   logic [WIDTH-1:0] dec_q;
   assign up    = m == DIR_UP;
   assign inc_q = WIDTH'({1'b0, q} + ONE);
   assign dec_q = WIDTH'({1'b0, q} - ONE);
   // Up terminates at or above max; down terminates only at zero, an out-of-range value snaps to max
   always_comb begin
      term   = up ? (q >= max) : (q == '0);
      next_q = up ? (term ? (sat ? max : '0) : inc_q)
                  : (q == '0) ? (sat ? '0 : max) : (q > max) ? max : dec_q;
   end
endmodule

// File: rtl/counter_nbit_mod.sv
// counter_nbit_mod: parametrised modulus up/down counter with load, wrap/saturate and terminal-event tracking
import counter_pkg::*;

module counter_nbit_mod #(
   parameter int WIDTH   = 8,
   parameter int EVT_W   = 4,
   parameter int RST_VAL = 0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             E,
   input  logic             M,
   input  logic             Ld,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] Max,
   input  logic             Sat,
   input  logic             Clr_ovf,
   output logic [WIDTH-1:0] Q,
   output logic             Cout,
   output logic             Ovf,
   output logic [EVT_W-1:0] Evt
);
   logic [WIDTH-1:0] next_q;
   logic             term;
   logic             hit;
   counter_nbit_next #(.WIDTH(WIDTH)) u_next (
      .q      (Q),
      .max    (Max),
      .m      (M),
      .sat    (Sat),
      .next_q (next_q),
      .term   (term)
   );
   assign hit = !Ld && E && term;
   // Count/load register with terminal pulse; a terminal event beats a same-edge clear
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Q    <= WIDTH'(RST_VAL);
         Cout <= 1'b0;
         Ovf  <= 1'b0;
         Evt  <= '0;
      end else begin
         Q    <= Ld ? D : E ? next_q : Q;
         Cout <= hit;
         Ovf  <= hit | (Ovf & !Clr_ovf);
         Evt  <= hit ? (Clr_ovf ? EVT_W'(1) : EVT_W'(sat_inc(32'(Evt), EVT_W)))
                     : (Clr_ovf ? '0 : Evt);
      end
   end
endmodule

// File: doc/counter_nbit_mod.md
Name: counter_nbit_mod

Overview:
- Parametrised successor to the team's fixed 8-bit up/down counter.
- Provides:
  - WIDTH-bit up/down counting with a programmable modulus (terminal value Max).
  - Parallel load.
  - Selectable wrap or saturate mode.
  - A registered terminal-count pulse, a sticky overflow flag, and a saturating terminal-event tally.
- Used as the generic timebase/event counter in datapath and test-infrastructure blocks.

Parameters:
- WIDTH, 8: counter width in bits (must be >= 2).
- EVT_W, 4: width of the terminal-event tally Evt.
- RST_VAL, 0: value of Q after reset. Must be <= 2^WIDTH-1.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- E  input  1  count enable.
- M  input  1  direction: 1 = up, 0 = down.
- Ld  input  1  parallel load strobe.
- D  input  WIDTH  load value.
- Max  input  WIDTH  terminal (highest) count value; the modulus is Max+1.
- Sat  input  1  1 = saturate at the bounds, 0 = wrap.
- Clr_ovf  input  1  clears Ovf and Evt.
- Q  output  WIDTH  count value, registered.
- Cout  output  1  one-cycle terminal-count pulse, registered.
- Ovf  output  1  sticky terminal-event flag.
- Evt  output  EVT_W  saturating count of terminal events.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high. Clock port is Clk, reset port is Reset.
  - On Reset: Q=RST_VAL, Cout=0, Ovf=0, Evt=0. Reset overrides all other inputs in that cycle.
  - A mid-count Reset takes effect at the next edge with no residual Cout.
- Per-edge priority: Reset > Ld > E. E=0 with Ld=0 holds Q; Cout=0 in that cycle.
- Ld:
  - Q<=D, Cout<=0, and Ovf/Evt are unchanged.
  - E is ignored in the load cycle.
  - D is not clamped to Max.
- Up count (E=1, M=1):
  - Q<Max: Q<=Q+1.
  - Q>=Max is a terminal event.
    - Sat=0: Q<=0.
    - Sat=1: Q<=Max.
- Down count (E=1, M=0):
  - 0<Q<=Max: Q<=Q-1.
  - Q==0 is a terminal event.
    - Sat=0: Q<=Max.
    - Sat=1: Q stays 0.
  - Q>Max (possible after a Ld or a change to Max): Q<=Max. This is not a terminal event.
- Terminal event, registered, visible the cycle after the causing edge together with the new Q:
  - Cout=1 for exactly that cycle.
  - Ovf set to 1.
  - Evt incremented, saturating at 2^EVT_W-1.
  - In Sat mode, every enabled cycle spent at the bound is a terminal event, so Cout stays high continuously.
- Clr_ovf:
  - Clears Ovf and Evt at the edge.
  - If a terminal event occurs on the same edge, the set wins: Ovf=1 and Evt=1.
- Arithmetic:
  - Unsigned throughout. Next-state values are computed at WIDTH+1 bits and truncated.
  - Max=2^WIDTH-1 behaves exactly like a plain binary counter.
  - Max=0 with Sat=0: Q stays 0 and Cout=1 on every enabled cycle.
- Max and Sat may change on any cycle. They are sampled on each edge; there is no internal latching.
- No combinational path from any input to any output.

Decomposition:
- Package counter_pkg holds:
  - localparams DIR_UP=1'b1, DIR_DN=1'b0.
  - A function sat_inc(value, width) for the Evt tally.
- One natural combinational sub-module, counter_nbit_next. It takes Q, Max, M, Sat and outputs next_q and term.
- The top level instantiates counter_nbit_next plus the registers for Q, Cout, Ovf and Evt.
- Implementation is 150-250 lines in total.

Test Plan:
- Reset, then E=0 for 5 cycles -> Q=00, Cout=0, Ovf=0, Evt=0. Reset asserted mid-count at Q=37 -> Q=00 on the next edge, Cout=0.
- Max=FF, Sat=0, M=1, E=1 from 00 for 256 edges -> Q=00. Cout=1 only in the cycle after the FF->00 edge. Ovf=1, Evt=1.
- Max=09, Sat=0, M=1, 25 edges from 00 -> Q sequence 0..9,0..9,0..4 and Cout pulses=2. Then M=0 for 6 edges -> Q=4,3,2,1,0,9 with Cout=1 once.
- Max=05, Sat=1, M=1, 8 edges from 00 -> Q sticks at 05. Cout high for the final 3 cycles; Evt=3.
- Ld=1, D=C8 with Max=09 -> Q=C8, no Cout. Then M=1, E=1 -> Q=00, Cout=1. Reload C8, then M=0 -> Q=09, Cout=0.
- Ovf=1 with Clr_ovf=1 on the same edge as a terminal event -> Ovf=1, Evt=1. Clr_ovf alone -> Ovf=0, Evt=0. With EVT_W=4, 20 wraps -> Evt=F (saturated).
